ifetch_unit: RTL and testbench

//  Instruction fetch front-end. Drives the 64-bit instruction memory port (i_* bus) and splits each

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/inst_fifo.sv | 88 ++++++++
 rtl/ifetch_unit.sv | 114 +++++++++++
 tb/tb_ifetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch front-end.
// One buffered instruction is a PC plus its 32-bit word.
package ifetch_pkg;

    localparam int INST_WIDTH = 32;
    localparam int BEAT_BYTES = 8;
    localparam int PC_WIDTH   = 32;

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] data;
    } inst_t;

endpackage

// File: rtl/inst_fifo.sv
// Instruction buffer: up to two pushes and one pop per cycle.
// Head entry is registered so decode sees flop outputs only.
module inst_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [1:0]    push_cnt,
    input  inst_t         push_a,
    input  inst_t         push_b,
    input  logic          pop,
    output logic [CW-1:0] free,
    output logic          head_valid,
    output inst_t         head
);

    localparam int PW = $clog2(DEPTH);

    inst_t          mem_q [DEPTH];
    inst_t          mem_d [DEPTH];
    logic [PW-1:0]  rd_q, rd_d;
    logic [PW-1:0]  wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           valid_q, valid_d;
    inst_t          head_q, head_d;
    logic           do_pop;

    assign free       = CW'(DEPTH) - cnt_q;
    assign head_valid = valid_q;
    assign head       = head_q;

    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        head_d  = '0;
        valid_d = 1'b0;
        do_pop  = pop && (cnt_q != '0);
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem_d[wr_q] = push_a;
            end
            if (push_cnt == 2'd2) begin
                mem_d[wr_q + PW'(1)] = push_b;
            end
            wr_d  = wr_q + PW'(push_cnt);
            rd_d  = rd_q + PW'(do_pop);
            cnt_d = cnt_q + CW'(push_cnt) - CW'(do_pop);
            // New head comes from storage unless the fifo drains this cycle
            if ((cnt_q - CW'(do_pop)) != '0) begin
                head_d = mem_q[rd_d];
            end else if (push_cnt != 2'd0) begin
                head_d = push_a;
            end
            valid_d = (cnt_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            head_q  <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: issues 64-bit beats, splits them into
// two instructions and hands them to decode in order.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = PC_WIDTH,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  i_ncs,
    output logic                  i_nwe,
    output logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] i_wmask,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_stall,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ~ADDR_WIDTH'(BEAT_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [CW:0] NEED_IDLE = (CW + 1)'(2);
    localparam logic [CW:0] NEED_BUSY = (CW + 1)'(4);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] req_base;
    logic [CW-1:0]         free;
    logic                  req;
    logic                  accept;
    logic [1:0]            push_cnt;
    inst_t                 push_a, push_b;
    inst_t                 head;

    // Only request when the fifo can absorb this beat plus any in flight
    always_comb begin
        req        = !rst && !redirect_valid &&
                     ({1'b0, free} >= (inflight_q ? NEED_BUSY : NEED_IDLE));
        accept     = req && i_stall;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & WORD_MASK;
        end else if (accept) begin
            fetch_pc_d = (fetch_pc_q & BEAT_MASK) + ADDR_WIDTH'(BEAT_BYTES);
        end
        inflight_d = accept;
        req_pc_d   = accept ? fetch_pc_q : req_pc_q;
    end

    always_comb begin
        req_base = req_pc_q & BEAT_MASK;
        push_cnt = 2'd0;
        push_a   = '0;
        push_b   = '0;
        if (inflight_q && !redirect_valid) begin
            if (req_pc_q[2]) begin
                push_cnt = 2'd1;
                push_a   = '{pc: req_base + ADDR_WIDTH'(4),
                             data: i_rdata[63:32]};
            end else begin
                push_cnt = 2'd2;
                push_a   = '{pc: req_base, data: i_rdata[31:0]};
                push_b   = '{pc: req_base + ADDR_WIDTH'(4),
                             data: i_rdata[63:32]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    inst_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push_cnt  (push_cnt),
        .push_a    (push_a),
        .push_b    (push_b),
        .pop       (inst_ready),
        .free      (free),
        .head_valid(inst_valid),
        .head      (head)
    );

    assign i_ncs     = !req;
    assign i_nwe     = 1'b1;
    assign i_addr    = fetch_pc_q & BEAT_MASK;
    assign i_wdata   = '0;
    assign i_wmask   = '0;
    assign inst_data = head.data;
    assign inst_pc   = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: memory model, PC-stream scoreboard,
// directed scenarios and a random redirect/stall run.
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        i_ncs, i_nwe;
    logic [31:0] i_addr;
    logic [63:0] i_wdata, i_wmask;
    logic [63:0] i_rdata = '0;
    logic        i_stall = 1'b1;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data, inst_pc;

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;

    ifetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(64),
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .i_ncs         (i_ncs),
        .i_nwe         (i_nwe),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .i_wmask       (i_wmask),
        .i_rdata       (i_rdata),
        .i_stall       (i_stall),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory image: word at byte address a (addi x1,x0,n pattern at low PCs)
    function automatic logic [31:0] word(input logic [31:0] a);
        return (((a >> 2) + 32'd1) << 20) | {12'h0, a[19:8], 8'h93};
    endfunction

    logic        mem_acc = 1'b0;
    logic [31:0] mem_addr = '0;

    always @(negedge clk) begin
        mem_acc  = !i_ncs && i_stall;
        mem_addr = i_addr;
    end

    always @(posedge clk) begin
        #1;
        i_rdata = mem_acc ? {word(mem_addr + 32'd4), word(mem_addr)}
                          : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // Scoreboard: expected PC stream is sequential from the last
    // reset or redirect target.
    logic [31:0] exp_q[$];
    logic [31:0] nxt = RESET_PC;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            exp_q.delete();
            nxt = RESET_PC;
        end else begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                check("sb_pc", inst_pc, e);
                check("sb_data", inst_data, word(e));
                n_pop++;
            end
            if (redirect_valid) begin
                exp_q.delete();
                nxt = redirect_pc & ~32'h3;
            end
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back(nxt);
            nxt = nxt + 32'd4;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One reset cycle; returns at the first post-reset cycle
    task automatic do_reset(input logic rdy);
        tick(1);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = rdy;
        i_stall        = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic get_pop(output logic [31:0] pc);
        bit found;
        found = 1'b0;
        pc    = '0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                pc    = inst_pc;
                found = 1'b1;
            end
        end
        if (!found) check("pop_timeout", 0, 1);
    endtask

    initial begin
        logic [31:0] pc;
        bit          seen;

        // Reset values
        rst = 1'b1;
        inst_ready = 1'b1;
        tick(2);
        @(negedge clk);
        check("rst_valid", inst_valid, 0);
        check("rst_ncs", i_ncs, 1);
        check("rst_nwe", i_nwe, 1);
        check("rst_addr", i_addr, RESET_PC & ~32'h7);
        check("rst_data", inst_data, 0);
        check("rst_pc", inst_pc, 0);
        check("rst_wdata", i_wdata, 0);
        check("rst_wmask", i_wmask, 0);

        // First fetch latency
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("req_lat", i_ncs, 0);
        check("req_addr", i_addr, 0);
        @(negedge clk);
        check("c1_valid", inst_valid, 0);
        @(negedge clk);
        check("c2_valid", inst_valid, 1);
        check("c2_data", inst_data, 32'h0010_0093);
        check("c2_pc", inst_pc, 0);
        @(negedge clk);
        check("c3_data", inst_data, 32'h0020_0093);
        check("c3_pc", inst_pc, 4);

        // Back-pressure: fifo fills, requests stop
        do_reset(1'b0);
        tick(10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_ncs", i_ncs, 1);
            check("full_pc", inst_pc, 0);
        end
        tick(1);
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            get_pop(pc);
            check("drain_pc", pc, 32'(i * 4));
        end

        // Memory stall holds the beat address
        do_reset(1'b1);
        tick(1);
        i_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ncs", i_ncs, 0);
            check("stall_addr", i_addr, 32'h8);
        end
        tick(1);
        i_stall = 1'b1;
        tick(20);

        // Redirect to an odd word with a response in flight
        do_reset(1'b0);
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h106;
        inst_ready     = 1'b1;
        @(negedge clk);
        check("redir_ncs", i_ncs, 1);
        tick(1);
        redirect_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", inst_valid, 0);
        get_pop(pc);
        check("redir_pc0", pc, 32'h104);
        check("redir_data0", inst_data, word(32'h104));
        get_pop(pc);
        check("redir_pc1", pc, 32'h108);

        // Redirect coinciding with a pop
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick(1);
            seen = inst_valid;
        end
        check("pre_pop_valid", inst_valid, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick(1);
        redirect_valid = 1'b0;
        get_pop(pc);
        check("pop_redir_pc", pc, 32'h300);

        // Reset in the middle of fetching
        tick(3);
        rst        = 1'b1;
        inst_ready = 1'b0;
        tick(1);
        @(negedge clk);
        check("mid_rst_valid", inst_valid, 0);
        check("mid_rst_ncs", i_ncs, 1);
        check("mid_rst_addr", i_addr, RESET_PC & ~32'h7);
        tick(1);
        rst        = 1'b0;
        inst_ready = 1'b1;
        get_pop(pc);
        check("restart_pc", pc, RESET_PC);

        // Random ready/stall/redirect, including targets that wrap
        n_pop = 0;
        for (int c = 0; c < 10000; c++) begin
            tick(1);
            inst_ready     = ($urandom_range(0, 9) < 7);
            i_stall        = ($urandom_range(0, 9) < 8);
            redirect_valid = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else
                redirect_pc = $urandom & 32'h000F_FFFF;
        end
        tick(1);
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        i_stall        = 1'b1;
        tick(20);
        check("progress", (n_pop > 1000), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
